// File: rtl/fasm_wrseq.sv
// fasm_wrseq: initiator-side sequencer for the X (read/write) port of the dual-port async memory.
// Serves single host accesses over a stb/ack handshake and performs whole-memory fills.
module fasm_wrseq #(
    parameter int AW = 5,
    parameter int DW = 2
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [DW-1:0] dat_i,
    input  logic [AW-1:0] adr_i,
    input  logic          wre_i,
    input  logic          stb_i,
    output logic          ack_o,
    output logic [DW-1:0] dat_o,
    input  logic          fil_i,
    input  logic [DW-1:0] val_i,
    output logic          bsy_o,
    output logic          don_o,
    output logic [DW-1:0] xdat_o,
    output logic [AW-1:0] xadr_o,
    output logic          xwre_o,
    input  logic [DW-1:0] xdat_i
);
    typedef enum logic [2:0] {IDLE, ACC, ACK, FILL, DONE} state_t;

    localparam logic [AW:0] LAST = {1'b1, {AW{1'b0}}};

    state_t        state, state_nx;
    logic [AW:0]   cnt, cnt_nx;
    logic [DW-1:0] fval, fval_nx;
    logic [DW-1:0] dat_nx, xdat_nx;
    logic [AW-1:0] xadr_nx;
    logic          ack_nx, bsy_nx, don_nx;
    logic          xwre_r, xwre_nx;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= IDLE;
            cnt    <= '0;
            fval   <= '0;
            ack_o  <= 1'b0;
            dat_o  <= '0;
            bsy_o  <= 1'b0;
            don_o  <= 1'b0;
            xdat_o <= '0;
            xadr_o <= '0;
            xwre_r <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            fval   <= fval_nx;
            ack_o  <= ack_nx;
            dat_o  <= dat_nx;
            bsy_o  <= bsy_nx;
            don_o  <= don_nx;
            xdat_o <= xdat_nx;
            xadr_o <= xadr_nx;
            xwre_r <= xwre_nx;
        end
    end

    // The memory samples write enable on the reset edge itself, so gate it
    // with reset to keep an in-flight write from landing.
    assign xwre_o = xwre_r & ~rst_i;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (fil_i) state_nx = FILL;
                     else if (stb_i) state_nx = ACC;
            ACC:     state_nx = ACK;
            ACK:     state_nx = IDLE;
            FILL:    if (cnt == LAST) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs are registered, so cnt runs one ahead of the address on xadr_o;
    // cnt == LAST means the last address is on the port this cycle.
    always_comb begin
        cnt_nx  = cnt;
        fval_nx = fval;
        ack_nx  = 1'b0;
        don_nx  = 1'b0;
        dat_nx  = dat_o;
        bsy_nx  = bsy_o;
        xdat_nx = xdat_o;
        xadr_nx = xadr_o;
        xwre_nx = xwre_r;
        case (state)
            IDLE: begin
                xwre_nx = 1'b0;
                bsy_nx  = 1'b0;
                if (fil_i) begin
                    fval_nx = val_i;
                    cnt_nx  = {{AW{1'b0}}, 1'b1};
                    xadr_nx = '0;
                    xdat_nx = val_i;
                    xwre_nx = 1'b1;
                    bsy_nx  = 1'b1;
                end else if (stb_i) begin
                    xadr_nx = adr_i;
                    xdat_nx = dat_i;
                    xwre_nx = wre_i;
                end
            end
            ACC: begin
                dat_nx  = xdat_i;
                ack_nx  = 1'b1;
                xwre_nx = 1'b0;
            end
            ACK: ;
            FILL: begin
                bsy_nx = 1'b1;
                if (cnt == LAST) begin
                    xwre_nx = 1'b0;
                    don_nx  = 1'b1;
                end else begin
                    xadr_nx = cnt[AW-1:0];
                    xdat_nx = fval;
                    xwre_nx = 1'b1;
                    cnt_nx  = cnt + 1'b1;
                end
            end
            DONE: begin
                bsy_nx  = 1'b0;
                xwre_nx = 1'b0;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_fasm_wrseq.sv
// Bench for fasm_wrseq: models the asynchronous memory on the X port and keeps
// an expected memory image built from the host-access and fill rules.
module tb_fasm_wrseq;
    localparam int AW = 5;
    localparam int DW = 2;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_i, wre_i, stb_i, fil_i;
    logic [DW-1:0] dat_i, val_i;
    logic [AW-1:0] adr_i;
    logic          ack_o, bsy_o, don_o, xwre_o;
    logic [DW-1:0] dat_o, xdat_o, xdat_i;
    logic [AW-1:0] xadr_o;

    fasm_wrseq #(.AW(AW), .DW(DW)) dut (
        .clk_i(clk), .rst_i(rst_i), .dat_i(dat_i), .adr_i(adr_i), .wre_i(wre_i),
        .stb_i(stb_i), .ack_o(ack_o), .dat_o(dat_o), .fil_i(fil_i), .val_i(val_i),
        .bsy_o(bsy_o), .don_o(don_o), .xdat_o(xdat_o), .xadr_o(xadr_o),
        .xwre_o(xwre_o), .xdat_i(xdat_i)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];
    bit seeded = 1'b0;
    int wcount = 0, cyc = 0, overlap = 0, ack_nostb = 0;
    int checks = 0, failures = 0;

    // Memory with asynchronous read; starts from a known non-uniform pattern.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!seeded) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= DW'(i * 3 + 1);
            seeded <= 1'b1;
        end else if (xwre_o) begin
            mem[xadr_o] <= xdat_o;
            wcount <= wcount + 1;
        end
        if (ack_o && don_o) overlap <= overlap + 1;
        if (ack_o && !stb_i) ack_nostb <= ack_nostb + 1;
    end
    assign xdat_i = mem[xadr_o];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        tick(); tick();
        checks++;
        if ({ack_o, don_o, bsy_o, xwre_o, dat_o, xdat_o, xadr_o} !== '0) begin
            failures++;
            $display("FAIL reset_state: outputs=%h expected 0", {ack_o, don_o, bsy_o, xwre_o, dat_o, xdat_o, xadr_o});
        end
        fil_i = 1'b1; stb_i = 1'b1; wre_i = 1'b1; adr_i = 5'd3; dat_i = 2'd1; val_i = 2'd2;
        tick();
        checks++;
        if ({ack_o, don_o, bsy_o, xwre_o, dat_o, xdat_o, xadr_o} !== '0) begin
            failures++;
            $display("FAIL reset_hold: outputs=%h expected 0", {ack_o, don_o, bsy_o, xwre_o, dat_o, xdat_o, xadr_o});
        end
        fil_i = 1'b0; stb_i = 1'b0; wre_i = 1'b0;
        rst_i = 1'b0;
        tick();
    endtask

    // One host access from IDLE: ack expected in the second cycle after the
    // sampling edge, returning the pre-access word.
    task automatic host_access(input logic [AW-1:0] a, input logic [DW-1:0] d,
                               input logic we, input string tag, output int ack_cyc);
        int w0;
        logic [DW-1:0] expd;
        expd = ref_mem[a];
        w0 = wcount;
        adr_i = a; dat_i = d; wre_i = we; stb_i = 1'b1;
        tick();
        checks++;
        if (ack_o !== 1'b0 || xwre_o !== we || xadr_o !== a || (we && xdat_o !== d)) begin
            failures++;
            $display("FAIL %s_acc: ack=%b xwre=%b adr=%0d xdat=%0d expected ack=0 xwre=%b adr=%0d", tag, ack_o, xwre_o, xadr_o, xdat_o, we, a);
        end
        tick();
        ack_cyc = cyc;
        checks++;
        if (ack_o !== 1'b1 || dat_o !== expd || xwre_o !== 1'b0) begin
            failures++;
            $display("FAIL %s_ack: ack=%b dat=%0d xwre=%b expected ack=1 dat=%0d xwre=0", tag, ack_o, dat_o, xwre_o, expd);
        end
        tick();
        stb_i = 1'b0;
        checks++;
        if (ack_o !== 1'b0 || (wcount - w0) != int'(we)) begin
            failures++;
            $display("FAIL %s_end: ack=%b writes=%0d expected ack=0 writes=%0d", tag, ack_o, wcount - w0, int'(we));
        end
        if (we) ref_mem[a] = d;
    endtask

    task automatic test_write_read();
        int c;
        host_access(5'd5, 2'd2, 1'b1, "wr5", c);
        host_access(5'd5, 2'd0, 1'b0, "rd5", c);
    endtask

    task automatic run_fill(input logic [DW-1:0] v, input bit noise, input string tag);
        int w0, n, cycles, dons, bad;
        w0 = wcount; n = 0; cycles = 0; dons = 0; bad = 0;
        fil_i = 1'b1; val_i = v;
        tick();
        fil_i = 1'b0;
        while (bsy_o === 1'b1 && cycles < 100) begin
            cycles++;
            if (don_o) begin
                dons++;
                fil_i = 1'b0;
            end else begin
                checks++;
                if (xwre_o !== 1'b1 || xadr_o !== AW'(n) || xdat_o !== v) begin
                    failures++;
                    $display("FAIL %s_write%0d: xwre=%b adr=%0d xdat=%0d expected xwre=1 adr=%0d xdat=%0d", tag, n, xwre_o, xadr_o, xdat_o, n, v);
                end
                n++;
                if (noise) begin
                    fil_i = 1'($urandom_range(0, 1));
                    val_i = DW'($urandom);
                end
            end
            tick();
        end
        fil_i = 1'b0;
        checks++;
        if (cycles != DEPTH + 1 || dons != 1 || n != DEPTH || (wcount - w0) != DEPTH) begin
            failures++;
            $display("FAIL %s_shape: bsy_cycles=%0d dons=%0d writes=%0d expected %0d 1 %0d", tag, cycles, dons, wcount - w0, DEPTH + 1, DEPTH);
        end
        for (int i = 0; i < DEPTH; i++) begin
            ref_mem[i] = v;
            if (mem[i] !== v) bad++;
        end
        checks++;
        if (bad != 0 || xwre_o !== 1'b0 || don_o !== 1'b0) begin
            failures++;
            $display("FAIL %s_contents: bad_words=%0d xwre=%b don=%b expected 0 0 0", tag, bad, xwre_o, don_o);
        end
    endtask

    task automatic test_fill_vs_stb();
        bit don_seen, got;
        int k;
        don_seen = 0; got = 0; k = 0;
        fil_i = 1'b1; val_i = 2'd3;
        stb_i = 1'b1; wre_i = 1'b0; adr_i = 5'd7;
        tick();
        fil_i = 1'b0;
        while (!got && k < 100) begin
            if (don_o) don_seen = 1;
            if (ack_o) got = 1;
            else tick();
            k++;
        end
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 2'd3;
        checks++;
        if (!got || !don_seen || dat_o !== ref_mem[7]) begin
            failures++;
            $display("FAIL fill_vs_stb: ack=%0d don_first=%0d dat=%0d expected 1 1 %0d", got, don_seen, dat_o, ref_mem[7]);
        end
        tick();
        stb_i = 1'b0;
    endtask

    task automatic test_reset_mid_fill();
        logic [DW-1:0] v;
        int dons, bsys, bad;
        dons = 0; bsys = 0; bad = 0;
        v = ref_mem[9] + 1'b1;
        fil_i = 1'b1; val_i = v;
        tick();
        fil_i = 1'b0;
        repeat (9) tick();
        checks++;
        if (xwre_o !== 1'b1 || xadr_o !== 5'd9) begin
            failures++;
            $display("FAIL rst_fill_pos: xwre=%b adr=%0d expected 1 9", xwre_o, xadr_o);
        end
        rst_i = 1'b1;
        #1;
        checks++;
        if (xwre_o !== 1'b0) begin
            failures++;
            $display("FAIL rst_fill_gate: xwre=%b expected 0", xwre_o);
        end
        tick();
        rst_i = 1'b0;
        checks++;
        if ({ack_o, don_o, bsy_o, xwre_o, dat_o, xdat_o, xadr_o} !== '0) begin
            failures++;
            $display("FAIL rst_fill_out: outputs=%h expected 0", {ack_o, don_o, bsy_o, xwre_o, dat_o, xdat_o, xadr_o});
        end
        repeat (40) begin
            tick();
            if (don_o) dons++;
            if (bsy_o) bsys++;
        end
        for (int i = 0; i < 9; i++) ref_mem[i] = v;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) bad++;
        checks++;
        if (dons != 0 || bsys != 0 || bad != 0) begin
            failures++;
            $display("FAIL rst_fill_after: dons=%0d bsy=%0d bad_words=%0d expected 0 0 0", dons, bsys, bad);
        end
    endtask

    task automatic test_back_to_back();
        int c [4];
        int w0;
        w0 = wcount;
        for (int i = 0; i < 4; i++)
            host_access(AW'(i), DW'($urandom), 1'b1, "b2b_wr", c[i]);
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (c[i] - c[i-1] != 3) begin
                failures++;
                $display("FAIL b2b_period%0d: cycles=%0d expected 3", i, c[i] - c[i-1]);
            end
        end
        checks++;
        if (wcount - w0 != 4) begin
            failures++;
            $display("FAIL b2b_count: writes=%0d expected 4", wcount - w0);
        end
        for (int i = 0; i < 4; i++)
            host_access(AW'(i), 2'd0, 1'b0, "b2b_rd", c[0]);
    endtask

    task automatic test_random_access();
        int c;
        for (int i = 0; i < 12; i++)
            host_access(AW'($urandom), DW'($urandom), 1'($urandom_range(0, 1)), "rnd", c);
    endtask

    task automatic test_reset_in_acc();
        logic [AW-1:0] a;
        int acks;
        acks = 0;
        a = AW'($urandom);
        adr_i = a; dat_i = ~ref_mem[a]; wre_i = 1'b1; stb_i = 1'b1;
        tick();
        rst_i = 1'b1;
        #1;
        checks++;
        if (xwre_o !== 1'b0) begin
            failures++;
            $display("FAIL rst_acc_gate: xwre=%b expected 0", xwre_o);
        end
        tick();
        stb_i = 1'b0; rst_i = 1'b0;
        checks++;
        if ({ack_o, don_o, bsy_o, xwre_o, dat_o, xdat_o, xadr_o} !== '0 || mem[a] !== ref_mem[a]) begin
            failures++;
            $display("FAIL rst_acc: outputs=%h mem[%0d]=%0d expected 0 and %0d", {ack_o, don_o, bsy_o, xwre_o, dat_o, xdat_o, xadr_o}, a, mem[a], ref_mem[a]);
        end
        repeat (5) begin
            tick();
            if (ack_o) acks++;
        end
        checks++;
        if (acks != 0) begin
            failures++;
            $display("FAIL rst_acc_noack: acks=%0d expected 0", acks);
        end
    endtask

    initial begin
        rst_i = 1'b1; stb_i = 1'b0; fil_i = 1'b0; wre_i = 1'b0;
        dat_i = '0; val_i = '0; adr_i = '0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = DW'(i * 3 + 1);
        test_reset();
        test_write_read();
        run_fill(2'd3, 1'b0, "fill3");
        test_fill_vs_stb();
        test_reset_mid_fill();
        test_back_to_back();
        run_fill(DW'($urandom), 1'b1, "fill_noise");
        test_random_access();
        test_reset_in_acc();
        checks++;
        if (overlap != 0 || ack_nostb != 0) begin
            failures++;
            $display("FAIL protocol: ack_don_overlap=%0d ack_without_stb=%0d expected 0 0", overlap, ack_nostb);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time=%0t expected completion", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
